pool_window_feeder: RTL and testbench

POOL_WINDOW_FEEDER -- requirements
Module: pool_window_feeder

---
 rtl/pool_window_feeder.sv | 135 +++++++++++++
 tb/tb_pool_window_feeder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_feeder.sv
// Buffers one FM_SIZE x FM_SIZE frame, then streams every pooling window element-by-element
// (pad positions as most-negative) to a running-max stage, one element per cycle.
module pool_window_feeder #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 4,
  parameter int PADDING     = 0,
  parameter int STRIDE      = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic signed [47:0] i_data,
  output logic               o_ready,
  output logic signed [47:0] o_data,
  output logic               o_clean,
  output logic               o_en_mp,
  output logic               o_win_last,
  output logic               o_frame_done,
  output logic               o_busy
);
  localparam int OUT = (FM_SIZE + 2*PADDING - KERNEL_SIZE)/STRIDE + 1;
  localparam int N   = FM_SIZE*FM_SIZE;
  localparam int KW  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int OW  = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int AW  = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [47:0] PAD_VAL = 48'sh8000_0000_0000;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [KW-1:0]     kr_q, kr_d, kc_q, kc_d;
  logic [OW-1:0]     orow_q, orow_d, ocol_q, ocol_d;
  logic signed [47:0] data_q, data_d;
  logic              clean_q, clean_d, en_q, en_d, last_q, last_d, done_q, done_d;

  logic signed [47:0] mem [N];
  logic [AW-1:0]     rd_addr;
  int                r, c;
  logic              pad, kc_end, kr_end, win_end, ocol_end, frame_end;

  always_ff @(posedge i_clk) begin
    if (state_q == FILL && i_valid) mem[wr_addr_q] <= i_data;
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    data_d    = '0;
    clean_d   = 1'b1;
    en_d      = 1'b0;
    last_d    = 1'b0;
    done_d    = 1'b0;
    r         = int'(orow_q)*STRIDE + int'(kr_q) - PADDING;
    c         = int'(ocol_q)*STRIDE + int'(kc_q) - PADDING;
    pad       = (r < 0) || (r >= FM_SIZE) || (c < 0) || (c >= FM_SIZE);
    rd_addr   = AW'(r*FM_SIZE + c);
    kc_end    = (kc_q == KW'(KERNEL_SIZE-1));
    kr_end    = (kr_q == KW'(KERNEL_SIZE-1));
    win_end   = kc_end && kr_end;
    ocol_end  = (ocol_q == OW'(OUT-1));
    frame_end = win_end && ocol_end && (orow_q == OW'(OUT-1));

    case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        if (i_valid) begin
          if (wr_addr_q == AW'(N-1)) begin
            wr_addr_d = '0;
            state_d   = DRAIN;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        en_d    = 1'b1;
        clean_d = (kr_q == '0) && (kc_q == '0);
        last_d  = win_end;
        data_d  = pad ? PAD_VAL : mem[rd_addr];
        kc_d    = kc_end ? '0 : kc_q + 1'b1;
        if (kc_end) kr_d = kr_end ? '0 : kr_q + 1'b1;
        if (win_end) ocol_d = ocol_end ? '0 : ocol_q + 1'b1;
        // orow advances per output row and wraps only at frame end
        if (win_end && ocol_end) orow_d = frame_end ? '0 : orow_q + 1'b1;
        if (frame_end) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      data_q    <= '0;
      clean_q   <= 1'b1;
      en_q      <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      kr_q      <= kr_d;
      kc_q      <= kc_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      data_q    <= data_d;
      clean_q   <= clean_d;
      en_q      <= en_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  assign o_data       = data_q;
  assign o_clean      = clean_q;
  assign o_en_mp      = en_q;
  assign o_win_last   = last_q;
  assign o_frame_done = done_q;
  assign o_ready      = (state_q == FILL);
  assign o_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_pool_window_feeder.sv
// Scoreboard bench: three feeder configurations, expected elements and window maxima queued at stimulus time.
module tb_pool_window_feeder;
  localparam logic signed [47:0] PAD = 48'sh8000_0000_0000;

  typedef struct {
    logic signed [47:0] d;
    logic               cl;
    logic               wl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic               vld    [3];
  logic signed [47:0] dat    [3];
  logic               rdy_o  [3];
  logic signed [47:0] dat_o  [3];
  logic               cl_o   [3];
  logic               en_o   [3];
  logic               wl_o   [3];
  logic               fd_o   [3];
  logic               busy_o [3];

  always #5 clk = ~clk;

  pool_window_feeder #(.KERNEL_SIZE(3), .FM_SIZE(4), .PADDING(0), .STRIDE(1)) u_k3 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld[0]), .i_data(dat[0]), .o_ready(rdy_o[0]),
    .o_data(dat_o[0]), .o_clean(cl_o[0]), .o_en_mp(en_o[0]), .o_win_last(wl_o[0]),
    .o_frame_done(fd_o[0]), .o_busy(busy_o[0]));
  pool_window_feeder #(.KERNEL_SIZE(2), .FM_SIZE(4), .PADDING(0), .STRIDE(2)) u_k2s2 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld[1]), .i_data(dat[1]), .o_ready(rdy_o[1]),
    .o_data(dat_o[1]), .o_clean(cl_o[1]), .o_en_mp(en_o[1]), .o_win_last(wl_o[1]),
    .o_frame_done(fd_o[1]), .o_busy(busy_o[1]));
  pool_window_feeder #(.KERNEL_SIZE(3), .FM_SIZE(4), .PADDING(1), .STRIDE(1)) u_k3p1 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld[2]), .i_data(dat[2]), .o_ready(rdy_o[2]),
    .o_data(dat_o[2]), .o_clean(cl_o[2]), .o_en_mp(en_o[2]), .o_win_last(wl_o[2]),
    .o_frame_done(fd_o[2]), .o_busy(busy_o[2]));

  int checks = 0;
  int failures = 0;
  int sel = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int n_seen = 0;
  int fd_cnt = 0;
  exp_t exp_q[$];
  logic signed [47:0] max_q[$];
  logic signed [47:0] run_max = '0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  // Monitor: pops one expected element per o_en_mp cycle and tracks the downstream running max.
  always @(negedge clk) begin
    if (en_o[sel] === 1'b1) begin
      if (n_seen == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_elem actual=%0d expected=none", dat_o[sel]);
      end else begin
        e = exp_q.pop_front();
        chk("elem_data", dat_o[sel], e.d);
        chk("elem_clean", cl_o[sel], e.cl);
        chk("elem_win_last", wl_o[sel], e.wl);
      end
      run_max = (cl_o[sel] === 1'b1) ? dat_o[sel] : ((dat_o[sel] > run_max) ? dat_o[sel] : run_max);
      if (wl_o[sel] === 1'b1) begin
        if (max_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_win_max actual=%0d expected=none", run_max);
        end else begin
          chk("win_max", run_max, max_q.pop_front());
        end
      end
    end
    if (fd_o[sel] === 1'b1) fd_cnt++;
  end

  task automatic clear();
    n_seen = 0;
    fd_cnt = 0;
    exp_q.delete();
    max_q.delete();
  endtask

  task automatic push_elem(input logic signed [47:0] d, input int kr, input int kc, input int k);
    exp_t x;
    x.d  = d;
    x.cl = (kr == 0) && (kc == 0);
    x.wl = (kr == k-1) && (kc == k-1);
    exp_q.push_back(x);
  endtask

  // Frame model for input value = raster index on a 4x4 map; first `skip` windows omitted.
  task automatic push_model(input int k, input int s, input int p, input int skip);
    int outn = (4 + 2*p - k)/s + 1;
    for (int orow = 0; orow < outn; orow++)
      for (int ocol = 0; ocol < outn; ocol++)
        for (int kr = 0; kr < k; kr++)
          for (int kc = 0; kc < k; kc++) begin
            int r = orow*s + kr - p;
            int c = ocol*s + kc - p;
            if (orow*outn + ocol >= skip)
              push_elem((r < 0 || r > 3 || c < 0 || c > 3) ? PAD : 48'(r*4 + c), kr, kc, k);
          end
  endtask

  task automatic feed(input bit toggle, input bit drain_valid);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      int w = 0;
      while (rdy_o[sel] !== 1'b1 && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 50) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout actual=0 expected=1");
      end
      vld[sel] = 1'b1;
      dat[sel] = 48'(i);
      if (i == 15) acc_cyc = cyc;
      @(posedge clk); #1;
      if (toggle) begin
        vld[sel] = 1'b0;
        dat[sel] = 48'sd999;
        @(posedge clk); #1;
      end
    end
    vld[sel] = 1'b0;
    if (drain_valid) begin
      vld[sel] = 1'b1;
      dat[sel] = -48'sd7;
      repeat (30) @(posedge clk);
      #1;
      vld[sel] = 1'b0;
    end
  endtask

  task automatic wait_done(input int n_exp);
    int k = 0;
    while (!(fd_cnt >= 1 && exp_q.size() == 0) && k < 400) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 400) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout actual=%0d expected=%0d", n_seen, n_exp);
    end
    repeat (5) @(negedge clk);
    chk("elem_count", n_seen, n_exp);
    chk("frame_done_count", fd_cnt, 1);
    chk("maxima_left", max_q.size(), 0);
  endtask

  initial begin
    logic signed [47:0] w0 [9];
    int t2 [16];
    int m3 [16];
    w0 = '{PAD, PAD, PAD, PAD, 48'sd0, 48'sd1, PAD, 48'sd4, 48'sd5};
    t2 = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    m3 = '{5, 6, 7, 7, 9, 10, 11, 11, 13, 14, 15, 15, 13, 14, 15, 15};
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      dat[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en_mp", en_o[0], 0);
    chk("rst_clean", cl_o[0], 1);
    chk("rst_win_last", wl_o[0], 0);
    chk("rst_data", dat_o[0], 0);
    chk("rst_frame_done", fd_o[0], 0);
    chk("rst_ready", rdy_o[0], 0);
    chk("rst_busy", busy_o[0], 0);
    rst = 1'b0;

    // K3 FM4 P0 S1, input 0..15
    sel = 0;
    clear();
    push_model(3, 1, 0, 0);
    max_q = '{48'sd10, 48'sd11, 48'sd14, 48'sd15};
    feed(1'b0, 1'b0);
    wait_done(36);
    chk("first_latency", first_cyc - acc_cyc, 2);
    chk("drain_span", last_cyc - first_cyc, 35);

    // K2 FM4 P0 S2
    sel = 1;
    clear();
    for (int i = 0; i < 16; i++) push_elem(48'(t2[i]), (i % 4) / 2, i % 2, 2);
    max_q = '{48'sd5, 48'sd7, 48'sd13, 48'sd15};
    feed(1'b0, 1'b0);
    wait_done(16);

    // K3 FM4 P1 S1: hand-listed window 0, remaining windows from the frame model
    sel = 2;
    clear();
    for (int i = 0; i < 9; i++) push_elem(w0[i], i / 3, i % 3, 3);
    push_model(3, 1, 1, 1);
    for (int i = 0; i < 16; i++) max_q.push_back(48'(m3[i]));
    feed(1'b0, 1'b0);
    wait_done(144);

    // Gapped valid during FILL, valid held high with junk during DRAIN
    sel = 0;
    clear();
    push_model(3, 1, 0, 0);
    max_q = '{48'sd10, 48'sd11, 48'sd14, 48'sd15};
    feed(1'b1, 1'b1);
    wait_done(36);
    chk("gap_first_latency", first_cyc - acc_cyc, 2);

    // Reset on DRAIN element 20, then a fresh frame
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear();
    push_model(3, 1, 0, 0);
    max_q = '{48'sd10, 48'sd11, 48'sd14, 48'sd15};
    feed(1'b0, 1'b0);
    begin
      int k = 0;
      while (n_seen < 20 && k < 100) begin
        @(negedge clk); #1;
        k++;
      end
      chk("elems_before_reset", n_seen, 20);
    end
    rst = 1'b1;
    exp_q.delete();
    max_q.delete();
    @(posedge clk); #1;
    chk("midrst_en_mp", en_o[0], 0);
    chk("midrst_clean", cl_o[0], 1);
    chk("midrst_busy", busy_o[0], 0);
    chk("midrst_win_last", wl_o[0], 0);
    chk("midrst_data", dat_o[0], 0);
    rst = 1'b0;
    clear();
    push_model(3, 1, 0, 0);
    max_q = '{48'sd10, 48'sd11, 48'sd14, 48'sd15};
    feed(1'b0, 1'b0);
    wait_done(36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
